// File: rtl/gottagofast_pkg.sv
// Shared constants for the FastRAM autoconfig responder.
// Register offsets are ADDR[8:1] values inside the $E8xxxx config space.
package gottagofast_pkg;

  localparam logic [7:0] REG_BASE   = 8'h24;
  localparam logic [7:0] REG_SHUTUP = 8'h26;

  localparam logic [3:0] ERT_SIZE_2M = 4'h6;
  localparam logic [3:0] ERT_TYPE    = 4'hE;

  typedef enum logic {
    OFFER = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/autoconfig_rom.sv
// Autoconfig ROM nibble lookup by config-space offset.
// Every block offered presents the same identity.
module autoconfig_rom
  import gottagofast_pkg::*;
#(
  parameter logic [15:0] MFG_ID  = 16'h07DB,
  parameter logic [7:0]  PROD_ID = 8'd69,
  parameter logic [15:0] SERIAL  = 16'd421
) (
  input  logic [7:0] i_off,
  output logic [3:0] o_nib
);

  localparam logic [15:0] MFG_N = ~MFG_ID;
  localparam logic [7:0]  PRD_N = ~PROD_ID;
  localparam logic [15:0] SER_N = ~SERIAL;

  always_comb begin
    o_nib = 4'hF;
    case (i_off)
      8'h00: o_nib = ERT_TYPE;
      8'h01: o_nib = ERT_SIZE_2M;
      8'h02: o_nib = PRD_N[7:4];
      8'h03: o_nib = PRD_N[3:0];
      8'h04: o_nib = ~4'h8;
      8'h05: o_nib = ~4'h0;
      8'h08: o_nib = MFG_N[15:12];
      8'h09: o_nib = MFG_N[11:8];
      8'h0A: o_nib = MFG_N[7:4];
      8'h0B: o_nib = MFG_N[3:0];
      8'h10: o_nib = SER_N[15:12];
      8'h11: o_nib = SER_N[11:8];
      8'h12: o_nib = SER_N[7:4];
      8'h13: o_nib = SER_N[3:0];
      8'h20: o_nib = 4'h0;
      8'h21: o_nib = 4'h0;
      default: o_nib = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_ctrl.sv
// Zorro II autoconfig responder for the 8MB FastRAM card.
// Offers up to NUM_BLOCKS 2MB blocks, then passes the chain on.
module autoconfig_ctrl
  import gottagofast_pkg::*;
#(
  parameter logic [15:0] MFG_ID     = 16'h07DB,
  parameter logic [7:0]  PROD_ID    = 8'd69,
  parameter logic [15:0] SERIAL     = 16'd421,
  parameter int          NUM_BLOCKS = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        CFGINn,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        RWn,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DBUS_IN,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  output logic        CFGOUTn,
  output logic [7:0]  addr_match,
  output logic        configured,
  output logic [1:0]  block_idx
);

  localparam logic [1:0] LAST = 2'(NUM_BLOCKS - 1);

  logic       r_as_q;
  logic       r_uds_q;
  logic       r_rw_q;
  logic       r_cfgin;
  logic       r_taken;
  state_e     r_state;
  logic [3:0] r_dout;
  logic       r_cfgout;
  logic [7:0] r_match;
  logic       r_conf;
  logic [1:0] r_idx;

  logic [7:0] w_off;
  logic [3:0] w_rom;
  logic       w_as_rise;
  logic       w_cfg_sel;
  logic       w_wr_stb;
  logic [7:0] w_grant;

  assign w_off     = ADDR[8:1];
  assign w_as_rise = !r_as_q && ASn;
  assign w_cfg_sel = (ADDR[23:16] == 8'hE8) && !r_cfgin
                   && (r_state != DONE);
  assign w_wr_stb  = w_cfg_sel && !r_as_q && !r_rw_q
                   && !r_uds_q && !r_taken;

  autoconfig_rom #(
    .MFG_ID (MFG_ID),
    .PROD_ID(PROD_ID),
    .SERIAL (SERIAL)
  ) u_rom (
    .i_off(w_off),
    .o_nib(w_rom)
  );

  // Base value 2/4/6/8 selects the 2MB pair $200000/$400000/...
  always_comb begin
    w_grant = 8'h00;
    case (DBUS_IN)
      4'h2: w_grant = 8'h03;
      4'h4: w_grant = 8'h0C;
      4'h6: w_grant = 8'h30;
      4'h8: w_grant = 8'hC0;
      default: w_grant = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_as_q   <= 1'b1;
      r_uds_q  <= 1'b1;
      r_rw_q   <= 1'b1;
      r_cfgin  <= 1'b1;
      r_taken  <= 1'b0;
      r_state  <= OFFER;
      r_dout   <= 4'hF;
      r_cfgout <= 1'b1;
      r_match  <= 8'h00;
      r_conf   <= 1'b0;
      r_idx    <= 2'd0;
    end else begin
      r_as_q  <= ASn;
      r_uds_q <= UDSn;
      r_rw_q  <= RWn;
      if (w_as_rise)
        r_cfgin <= CFGINn;
      if (w_as_rise)
        r_taken <= 1'b0;
      else if (w_wr_stb)
        r_taken <= 1'b1;
      if (w_cfg_sel && RWn)
        r_dout <= w_rom;
      if (w_wr_stb) begin
        unique case (1'b1)
          (w_off == REG_BASE): begin
            r_match <= r_match | w_grant;
            r_conf  <= 1'b1;
            if (r_idx == LAST)
              r_state <= DONE;
            else
              r_idx <= r_idx + 2'd1;
          end
          (w_off == REG_SHUTUP): r_state <= DONE;
          default: ;
        endcase
      end
      // Chain hands over only once the final config cycle has ended
      if (w_as_rise && (r_state == DONE))
        r_cfgout <= 1'b0;
    end
  end

  assign DBUS_OE    = RESETn && w_cfg_sel && RWn && !ASn && !UDSn;
  assign DBUS_OUT   = r_dout;
  assign CFGOUTn    = r_cfgout;
  assign addr_match = r_match;
  assign configured = r_conf;
  assign block_idx  = r_idx;

endmodule
